// File: rtl/poly_pkg.sv
// Shared types and encodings for the Horner polynomial sequencer.
package poly_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_X = 3'd1,
        INIT   = 3'd2,
        MUL    = 3'd3,
        ADD    = 3'd4,
        DONE   = 3'd5
    } state_e;

    localparam logic [1:0] SEL_A_X_IN  = 2'b00;
    localparam logic [1:0] SEL_A_REG_X = 2'b01;
    localparam logic [1:0] SEL_A_REG_S = 2'b10;
    localparam logic [1:0] SEL_A_COEF  = 2'b11;

    localparam logic [1:0] SEL_B_ZERO  = 2'b00;
    localparam logic [1:0] SEL_B_REG_X = 2'b01;
    localparam logic [1:0] SEL_B_REG_S = 2'b10;
    localparam logic [1:0] SEL_B_COEF  = 2'b11;

    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_MUL = 1'b1;

endpackage

// File: rtl/poly_ctrl_decode.sv
// Combinational decode of sequencer state and coefficient index into ALU control lines.
// With ALU_WAIT_EN defined, the MUL-state S load is gated by alu_ready_i.
module poly_ctrl_decode
    import poly_pkg::*;
#(
    parameter int unsigned DEGREE = 2,
    parameter int unsigned AW     = 2
) (
    input  state_e          state_i,
    input  logic [AW-1:0]   idx_i,
`ifdef ALU_WAIT_EN
    input  logic            alu_ready_i,
`endif
    output logic            busy_o,
    output logic            done_o,
    output logic            load_x_o,
    output logic            load_s_o,
    output logic            alu_mul_o,
    output logic [1:0]      sel_a_o,
    output logic [1:0]      sel_b_o,
    output logic [AW-1:0]   coef_addr_o
);

    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        load_x_o    = 1'b0;
        load_s_o    = 1'b0;
        alu_mul_o   = ALU_ADD;
        sel_a_o     = SEL_A_X_IN;
        sel_b_o     = SEL_B_ZERO;
        coef_addr_o = '0;
        unique case (state_i)
            IDLE: begin
            end
            LOAD_X: begin
                busy_o   = 1'b1;
                load_x_o = 1'b1;
            end
            INIT: begin
                busy_o      = 1'b1;
                load_s_o    = 1'b1;
                sel_a_o     = SEL_A_COEF;
                coef_addr_o = AW'(DEGREE);
            end
            MUL: begin
                busy_o    = 1'b1;
`ifdef ALU_WAIT_EN
                load_s_o  = alu_ready_i;
`else
                load_s_o  = 1'b1;
`endif
                sel_a_o   = SEL_A_REG_S;
                sel_b_o   = SEL_B_REG_X;
                alu_mul_o = ALU_MUL;
            end
            ADD: begin
                busy_o      = 1'b1;
                load_s_o    = 1'b1;
                sel_a_o     = SEL_A_REG_S;
                sel_b_o     = SEL_B_COEF;
                coef_addr_o = idx_i;
            end
            DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/poly_seq_ctrl.sv
// Horner-rule sequencer for the shared mul/add ALU; drives control lines only.
// Optional ALU_WAIT_EN adds alu_ready and stalls MUL until the multiplier result is valid.
module poly_seq_ctrl
    import poly_pkg::*;
#(
    parameter int unsigned DEGREE = 2,
    parameter int unsigned AW     = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
`ifdef ALU_WAIT_EN
    input  logic            alu_ready,
`endif
    output logic            busy,
    output logic            done,
    output logic            load_x,
    output logic            load_s,
    output logic            alu_mul,
    output logic [1:0]      sel_a,
    output logic [1:0]      sel_b,
    output logic [AW-1:0]   coef_addr
);

    state_e          state_q, state_d;
    logic [AW-1:0]   idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // idx walks coefficients D-1 down to 0; ADD at idx 0 exits instead of wrapping
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD_X;
            end
            LOAD_X: begin
                state_d = INIT;
                idx_d   = AW'(DEGREE - 1);
            end
            INIT: state_d = MUL;
            MUL: begin
`ifdef ALU_WAIT_EN
                if (alu_ready) state_d = ADD;
`else
                state_d = ADD;
`endif
            end
            ADD: begin
                if (idx_q == '0) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q - AW'(1);
                    state_d = MUL;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    poly_ctrl_decode #(
        .DEGREE (DEGREE),
        .AW     (AW)
    ) u_decode (
        .state_i     (state_q),
        .idx_i       (idx_q),
`ifdef ALU_WAIT_EN
        .alu_ready_i (alu_ready),
`endif
        .busy_o      (busy),
        .done_o      (done),
        .load_x_o    (load_x),
        .load_s_o    (load_s),
        .alu_mul_o   (alu_mul),
        .sel_a_o     (sel_a),
        .sel_b_o     (sel_b),
        .coef_addr_o (coef_addr)
    );

endmodule

// File: tb/tb_poly_seq_ctrl.sv
// Self-checking bench for poly_seq_ctrl: D=2 and D=1 instances driving a behavioural ALU datapath.
// Define ALU_WAIT_EN to also exercise the multiplier stall path.
module tb_poly_seq_ctrl;
    import poly_pkg::*;

    localparam int unsigned AW = 2;

    logic clk = 1'b0;
    logic reset;
    logic start_a, start_b;
    logic alu_ready;

    logic          busy_a, done_a, load_x_a, load_s_a, alu_mul_a;
    logic [1:0]    sel_a_a, sel_b_a;
    logic [AW-1:0] coef_addr_a;
    logic          busy_b, done_b, load_x_b, load_s_b, alu_mul_b;
    logic [1:0]    sel_a_b, sel_b_b;
    logic [AW-1:0] coef_addr_b;

    int n_chk = 0;
    int n_bad = 0;
    int n_done_a = 0;
    int n_done_b = 0;

    logic [31:0] x_in;
    logic [31:0] coef [0:3];
    logic [31:0] xr_a, sr_a, xr_b, sr_b;

    logic [10:0] exp_q [$];
    bit          rdy_q [$];

    always #5 clk = ~clk;

    poly_seq_ctrl #(.DEGREE(2), .AW(AW)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .start     (start_a),
`ifdef ALU_WAIT_EN
        .alu_ready (alu_ready),
`endif
        .busy      (busy_a),
        .done      (done_a),
        .load_x    (load_x_a),
        .load_s    (load_s_a),
        .alu_mul   (alu_mul_a),
        .sel_a     (sel_a_a),
        .sel_b     (sel_b_a),
        .coef_addr (coef_addr_a)
    );

    poly_seq_ctrl #(.DEGREE(1), .AW(AW)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .start     (start_b),
`ifdef ALU_WAIT_EN
        .alu_ready (alu_ready),
`endif
        .busy      (busy_b),
        .done      (done_b),
        .load_x    (load_x_b),
        .load_s    (load_s_b),
        .alu_mul   (alu_mul_b),
        .sel_a     (sel_a_b),
        .sel_b     (sel_b_b),
        .coef_addr (coef_addr_b)
    );

    function automatic logic [31:0] opnd(input bit is_a, input logic [1:0] s,
                                         input logic [31:0] xr, input logic [31:0] sr,
                                         input logic [31:0] cf);
        case (s)
            2'b00:   return is_a ? x_in : 32'd0;
            2'b01:   return xr;
            2'b10:   return sr;
            default: return cf;
        endcase
    endfunction

    function automatic logic [31:0] alu_out(input logic mul, input logic [1:0] sa,
                                            input logic [1:0] sb, input logic [31:0] xr,
                                            input logic [31:0] sr, input logic [31:0] cf);
        logic [31:0] a, b;
        a = opnd(1'b1, sa, xr, sr, cf);
        b = opnd(1'b0, sb, xr, sr, cf);
        return mul ? a * b : a + b;
    endfunction

    // Behavioural X/S registers obeying whatever the sequencer commands
    always @(posedge clk) begin
        if (load_x_a) xr_a <= alu_out(alu_mul_a, sel_a_a, sel_b_a, xr_a, sr_a, coef[coef_addr_a]);
        if (load_s_a) sr_a <= alu_out(alu_mul_a, sel_a_a, sel_b_a, xr_a, sr_a, coef[coef_addr_a]);
        if (load_x_b) xr_b <= alu_out(alu_mul_b, sel_a_b, sel_b_b, xr_b, sr_b, coef[coef_addr_b]);
        if (load_s_b) sr_b <= alu_out(alu_mul_b, sel_a_b, sel_b_b, xr_b, sr_b, coef[coef_addr_b]);
        if (done_a) n_done_a <= n_done_a + 1;
        if (done_b) n_done_b <= n_done_b + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [10:0] ctl(input bit bsy, input bit dn, input bit lx, input bit ls,
                                        input bit ml, input logic [1:0] sa, input logic [1:0] sb,
                                        input logic [1:0] ad);
        return {bsy, dn, lx, ls, ml, sa, sb, ad};
    endfunction

    function automatic logic [10:0] cur_word(input bit use_b);
        if (use_b) return {busy_b, done_b, load_x_b, load_s_b, alu_mul_b, sel_a_b, sel_b_b, coef_addr_b};
        return {busy_a, done_a, load_x_a, load_s_a, alu_mul_a, sel_a_a, sel_b_a, coef_addr_a};
    endfunction

    // Expected per-cycle control words for one evaluation, stall cycles in the first MUL
    task automatic build(input int d, input int stall);
        exp_q.delete();
        rdy_q.delete();
        exp_q.push_back(ctl(1, 0, 1, 0, 0, 2'b00, 2'b00, 2'd0)); rdy_q.push_back(1);
        exp_q.push_back(ctl(1, 0, 0, 1, 0, 2'b11, 2'b00, 2'(d))); rdy_q.push_back(1);
        for (int k = d - 1; k >= 0; k--) begin
            if (k == d - 1) begin
                for (int s = 0; s < stall; s++) begin
                    exp_q.push_back(ctl(1, 0, 0, 0, 1, 2'b10, 2'b01, 2'd0)); rdy_q.push_back(0);
                end
            end
            exp_q.push_back(ctl(1, 0, 0, 1, 1, 2'b10, 2'b01, 2'd0)); rdy_q.push_back(1);
            exp_q.push_back(ctl(1, 0, 0, 1, 0, 2'b10, 2'b11, 2'(k))); rdy_q.push_back(1);
        end
        exp_q.push_back(ctl(1, 1, 0, 0, 0, 2'b00, 2'b00, 2'd0)); rdy_q.push_back(1);
    endtask

    function automatic logic [31:0] ref_poly(input int d);
        logic [31:0] p, pw;
        p  = 32'd0;
        pw = 32'd1;
        for (int i = 0; i <= d; i++) begin
            p  = p + coef[i] * pw;
            pw = pw * x_in;
        end
        return p;
    endfunction

    task automatic set_start(input bit use_b, input logic v);
        if (use_b) start_b = v;
        else       start_a = v;
    endtask

    // One evaluation from IDLE; optional start noise and reset abort at a given cycle index
    task automatic run(input bit use_b, input int d, input int stall, input bit noise, input int abort_at);
        int done0;
        int nd;
        build(d, stall);
        done0 = use_b ? n_done_b : n_done_a;
        alu_ready = rdy_q[0];
        set_start(use_b, 1'b1);
        @(posedge clk); #1;
        set_start(use_b, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) begin
            check_eq($sformatf("ctl_d%0d_c%0d", d, i + 1), 32'(cur_word(use_b)), 32'(exp_q[i]));
            if (i == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                nd = use_b ? n_done_b : n_done_a;
                check_eq("abort_idle", 32'(cur_word(use_b)), 32'd0);
                check_eq("abort_no_done", 32'(nd - done0), 32'd0);
                return;
            end
            if (noise && i >= 1 && i + 2 < exp_q.size()) set_start(use_b, 1'($urandom_range(0, 1)));
            else set_start(use_b, 1'b0);
            alu_ready = (i + 1 < exp_q.size()) ? rdy_q[i + 1] : 1'b1;
            @(posedge clk); #1;
        end
        nd = use_b ? n_done_b : n_done_a;
        check_eq("idle_after", 32'(cur_word(use_b)), 32'd0);
        check_eq("done_count", 32'(nd - done0), 32'd1);
        check_eq("result", use_b ? sr_b : sr_a, ref_poly(d));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        start_a   = 1'b0;
        start_b   = 1'b0;
        alu_ready = 1'b1;
        x_in      = 32'd0;
        for (int i = 0; i < 4; i++) coef[i] = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("reset_a", 32'(cur_word(1'b0)), 32'd0);
        check_eq("reset_b", 32'(cur_word(1'b1)), 32'd0);

        // Directed: x=3, c={1,2,3} gives 34
        x_in = 32'd3; coef[0] = 32'd1; coef[1] = 32'd2; coef[2] = 32'd3; coef[3] = 32'd0;
        run(1'b0, 2, 0, 1'b0, -1);
        check_eq("s_is_34", sr_a, 32'd34);

        // start noise during the run is ignored
        run(1'b0, 2, 0, 1'b1, -1);

        // Reset during second MUL, then a clean run
        run(1'b0, 2, 0, 1'b0, 4);
        run(1'b0, 2, 0, 1'b0, -1);

        // start held high: one IDLE cycle between runs, period 2*D+4
        @(posedge clk); #1;
        start_a = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            check_eq($sformatf("hold_done_c%0d", c), 32'(done_a), 32'((c % 8) == 7));
            check_eq($sformatf("hold_busy_c%0d", c), 32'(busy_a), 32'((c % 8) != 0));
        end
        start_a = 1'b0;
        for (int k = 0; k < 16 && busy_a; k++) begin
            @(posedge clk); #1;
        end
        check_eq("hold_drain", 32'(busy_a), 32'd0);

        // D=1 instance
        run(1'b1, 1, 0, 1'b0, -1);

`ifdef ALU_WAIT_EN
        x_in = 32'd3; coef[0] = 32'd1; coef[1] = 32'd2; coef[2] = 32'd3;
        run(1'b0, 2, 3, 1'b0, -1);
        check_eq("stall_s_is_34", sr_a, 32'd34);
`endif

        // Randomized evaluations on both instances
        for (int r = 0; r < 8; r++) begin
            x_in = 32'($urandom_range(0, 60));
            for (int i = 0; i < 4; i++) coef[i] = 32'($urandom_range(0, 200));
`ifdef ALU_WAIT_EN
            run(r[0], r[0] ? 1 : 2, $urandom_range(0, 3), 1'($urandom_range(0, 1)), -1);
`else
            run(r[0], r[0] ? 1 : 2, 0, 1'($urandom_range(0, 1)), -1);
`endif
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
